seg_bcd_converter: RTL and testbench
====================================

// Module: seg_bcd_converter
//
// PURPOSE
//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
//   Sits directly upstream of the 7-segment driver: a binary value goes in, and
//   packed BCD digits come out on out_bcd, which feeds the driver's 32-bit
//   number input.
//   out_bcd is a held register. It changes atomically, only when a conversion
//   completes, so the display never shows partial results.
//
// PARAMETERS
//   IN_WIDTH  32  width of the binary input, in bits (>=1)
//   DIGITS    8   number of BCD digits produced; out_bcd is 4*DIGITS bits wide (>=1)
//
// PORTS
//   clk       input   1           clock
//   resetn    input   1           reset: asynchronous, active-low
//   in_valid  input   1           in_value is valid
//   in_ready  output  1           converter is idle and can accept a value
//   in_value  input   IN_WIDTH    unsigned binary value to convert
//   out_bcd   output  4*DIGITS    packed BCD; digit i at [4i+3:4i], digit 0 is least significant
//   out_valid output  1           one-cycle pulse: out_bcd/overflow were just updated
//   overflow  output  1           last result did not fit in DIGITS digits
//
// BEHAVIOUR
//   Reset values:
//     - FSM in IDLE, in_ready=1, out_bcd=0, out_valid=0, overflow=0.
//     - Reset mid-conversion abandons the conversion; no out_valid is produced.
//   FSM states: IDLE and CONV.
//     - IDLE: in_ready=1. When in_valid&&in_ready at edge E0:
//         * capture in_value into the shift register;
//         * clear the scratch BCD register and the sticky overflow bit;
//         * load the bit counter with IN_WIDTH-1;
//         * go to CONV.
//     - CONV: in_ready=0, and in_valid is ignored.
//   Each CONV edge does one iteration, in this order:
//     - every scratch digit >=5 gets +3 (4-bit add, no inter-digit carry);
//     - then {scratch, shift} is shifted left by 1;
//     - the bit shifted out of the top scratch digit is ORed into sticky overflow.
//   Completion (the edge where counter==0, i.e. edge E_IN_WIDTH):
//     - out_bcd <= overflow ? all ones (0xF per digit; displays "FFFFFFFF")
//                           : the final scratch value;
//     - overflow output <= sticky value;
//     - out_valid <= 1 for exactly one cycle;
//     - FSM goes to IDLE.
//   Timing:
//     - Latency: result visible IN_WIDTH cycles after the accept edge
//       (32 with defaults).
//     - Throughput: at most one conversion per IN_WIDTH+1 cycles. in_ready
//       returns high in the same cycle out_valid is high, so in_valid held
//       continuously is accepted again at that cycle's edge.
//   Between completions:
//     - out_bcd and overflow hold their values;
//     - the previous value stays displayed while a new conversion runs.
//   Arithmetic:
//     - All arithmetic is unsigned.
//     - Values up to 10^DIGITS-1 convert exactly.
//     - 10^DIGITS and above set overflow.
//     - If 2^IN_WIDTH <= 10^DIGITS, overflow is constant 0.
//   Handshake:
//     - in_value is sampled only at the accept edge.
//     - Later changes to in_value do not affect an ongoing conversion.
//
// TESTING
//   1. in_value=0, 1-cycle in_valid -> in_ready low 32 cycles;
//      out_valid pulse at edge 32; out_bcd=0x00000000, overflow=0.
//   2. in_value=12345678 (0x00BC614E) -> out_bcd=0x12345678, overflow=0;
//      check out_bcd holds old value until completion edge.
//   3. in_value=99999999 -> out_bcd=0x99999999, overflow=0;
//      then in_value=100000000 -> out_bcd=0xFFFFFFFF, overflow=1;
//      then in_value=0xFFFFFFFF -> out_bcd=0xFFFFFFFF, overflow=1.
//   4. in_valid held high with values 7, 42 -> accepted 33 cycles apart;
//      out_bcd 0x00000007 then 0x00000042; in_value toggling while busy
//      has no effect.
//   5. Assert resetn low mid-conversion (cycle 10 of 12345678) ->
//      out_bcd=0, out_valid never pulses, in_ready=1 after release;
//      a next conversion of 5 gives 0x00000005.
//   6. Random in_value < 10^8 (>=1000 samples) vs a reference model ->
//      exact BCD match, overflow=0, every out_valid exactly one cycle.

Source files
------------

// File: rtl/seg_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3) feeding the 7-segment driver.
// out_bcd/overflow only change on the completion edge, so the display never shows partial results.
module seg_bcd_converter #(
    parameter int IN_WIDTH = 32,
    parameter int DIGITS   = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_WIDTH-1:0]   in_value,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_valid,
    output logic                  overflow
);

    localparam int CW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam int BW = 4 * DIGITS;

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t              state_q, state_d;
    logic [IN_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]       scratch_q, scratch_d;
    logic [CW-1:0]       bitCount_q, bitCount_d;
    logic                sticky_q, sticky_d;
    logic [BW-1:0]       outBcd_q, outBcd_d;
    logic                outValid_q, outValid_d;
    logic                overflow_q, overflow_d;
    logic [BW-1:0]       adjusted;

    // Each digit is corrected independently; a carry out of one digit never ripples into the next.
    always_comb begin
        adjusted = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        bitCount_d = bitCount_q;
        sticky_d   = sticky_q;
        outBcd_d   = outBcd_q;
        outValid_d = 1'b0;
        overflow_d = overflow_q;
        in_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shift_d    = in_value;
                    scratch_d  = '0;
                    sticky_d   = 1'b0;
                    bitCount_d = CW'(IN_WIDTH - 1);
                    state_d    = CONV;
                end
            end
            CONV: begin
                // A bit leaving the top digit means the value needs more than DIGITS digits.
                scratch_d  = {adjusted[BW-2:0], shift_q[IN_WIDTH-1]};
                shift_d    = shift_q << 1;
                sticky_d   = sticky_q | adjusted[BW-1];
                bitCount_d = bitCount_q - CW'(1);
                if (bitCount_q == '0) begin
                    outBcd_d   = sticky_d ? '1 : scratch_d;
                    overflow_d = sticky_d;
                    outValid_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            bitCount_q <= '0;
            sticky_q   <= 1'b0;
            outBcd_q   <= '0;
            outValid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            bitCount_q <= bitCount_d;
            sticky_q   <= sticky_d;
            outBcd_q   <= outBcd_d;
            outValid_q <= outValid_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_bcd   = outBcd_q;
    assign out_valid = outValid_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_seg_bcd_converter.sv
// Self-checking bench for seg_bcd_converter: a decimal reference model checked every cycle,
// plus directed conversions with hand-computed BCD results.
module tb_seg_bcd_converter;

    logic        clk;
    logic        resetn;
    logic        inValid;
    logic        inReady;
    logic [31:0] inValue;
    logic [31:0] outBcd;
    logic        outValid;
    logic        overflow;

    int checkCount = 0;
    int errorCount = 0;

    int          remaining = 0;
    logic [31:0] pendBcd   = '0;
    logic        pendOvf   = 1'b0;
    logic [31:0] expBcd    = '0;
    logic        expOvf    = 1'b0;
    logic        expValid  = 1'b0;
    logic        expReady  = 1'b1;

    seg_bcd_converter #(
        .IN_WIDTH(32),
        .DIGITS  (8)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (inValid),
        .in_ready (inReady),
        .in_value (inValue),
        .out_bcd  (outBcd),
        .out_valid(outValid),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal digit extraction; anything of nine or more digits saturates to all-F with overflow.
    function automatic logic [32:0] refConvert(input logic [31:0] value);
        longint unsigned x;
        logic [31:0]     bcd;
        x   = 64'(value);
        bcd = '0;
        if (x >= 64'd100000000) begin
            return {1'b1, 32'hFFFF_FFFF};
        end
        for (int i = 0; i < 8; i++) begin
            bcd[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return {1'b0, bcd};
    endfunction

    task automatic compare(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: checks what the DUT shows now, then predicts the state after the next edge.
    always @(negedge clk) begin
        if (!resetn) begin
            remaining = 0;
            expReady  = 1'b1;
            expValid  = 1'b0;
            expBcd    = '0;
            expOvf    = 1'b0;
        end
        compare("cycle in_ready", 64'(inReady), 64'(expReady));
        compare("cycle out_valid", 64'(outValid), 64'(expValid));
        compare("cycle out_bcd", 64'(outBcd), 64'(expBcd));
        compare("cycle overflow", 64'(overflow), 64'(expOvf));
        if (resetn) begin
            expValid = 1'b0;
            if (remaining > 0) begin
                remaining--;
                if (remaining == 0) begin
                    expValid = 1'b1;
                    expBcd   = pendBcd;
                    expOvf   = pendOvf;
                end
            end else if (inValid) begin
                {pendOvf, pendBcd} = refConvert(inValue);
                remaining          = 32;
            end
            expReady = (remaining == 0);
        end
    end

    task automatic applyStimulus(input logic [31:0] value);
        @(posedge clk);
        #1;
        inValid = 1'b1;
        inValue = value;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        inValue = $urandom;
    endtask

    task automatic waitResult(output int busyCycles, output bit seen);
        busyCycles = 0;
        seen       = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (outValid) seen = 1'b1;
            else if (!inReady) busyCycles++;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] bcd, input logic ovf);
        compare({name, " out_bcd"}, 64'(outBcd), 64'(bcd));
        compare({name, " overflow"}, 64'(overflow), 64'(ovf));
    endtask

    task automatic convertAndCheck(input string name, input logic [31:0] value,
                                   input logic [31:0] bcd, input logic ovf);
        int busy;
        bit seen;
        applyStimulus(value);
        waitResult(busy, seen);
        compare({name, " completed"}, 64'(seen), 64'd1);
        compare({name, " busy cycles"}, 64'(busy), 64'd32);
        checkOutput(name, bcd, ovf);
    endtask

    initial begin
        int          busy;
        bit          seen;
        int          pulses;
        logic [31:0] value;
        logic [32:0] ref33;

        resetn  = 1'b1;
        inValid = 1'b0;
        inValue = '0;
        #1 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        compare("reset in_ready", 64'(inReady), 64'd1);
        compare("reset out_valid", 64'(outValid), 64'd0);
        checkOutput("reset", 32'h0000_0000, 1'b0);

        convertAndCheck("zero", 32'd0, 32'h0000_0000, 1'b0);
        convertAndCheck("12345678", 32'h00BC_614E, 32'h1234_5678, 1'b0);
        convertAndCheck("99999999", 32'd99999999, 32'h9999_9999, 1'b0);
        convertAndCheck("100000000", 32'd100000000, 32'hFFFF_FFFF, 1'b1);
        convertAndCheck("all ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        convertAndCheck("9", 32'd9, 32'h0000_0009, 1'b0);

        // in_valid held high across two conversions while in_value churns during the first.
        @(posedge clk);
        #1;
        inValid = 1'b1;
        inValue = 32'd7;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            #1;
            inValue = $urandom;
        end
        @(posedge clk);
        #1;
        inValue = 32'd42;
        waitResult(busy, seen);
        compare("held 7 completed", 64'(seen), 64'd1);
        checkOutput("held 7", 32'h0000_0007, 1'b0);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        inValue = $urandom;
        waitResult(busy, seen);
        compare("held 42 completed", 64'(seen), 64'd1);
        compare("held 42 busy cycles", 64'(busy), 64'd32);
        checkOutput("held 42", 32'h0000_0042, 1'b0);

        // Reset in the middle of a conversion must discard it silently.
        applyStimulus(32'd12345678);
        repeat (10) @(posedge clk);
        #1 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        compare("midreset in_ready", 64'(inReady), 64'd1);
        checkOutput("midreset", 32'h0000_0000, 1'b0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (outValid) pulses++;
        end
        compare("midreset pulses", 64'(pulses), 64'd0);
        convertAndCheck("after reset 5", 32'd5, 32'h0000_0005, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            value = $urandom_range(99999999, 0);
            ref33 = refConvert(value);
            convertAndCheck("random", value, ref33[31:0], 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
